// File: rtl/code_mem_loadable_pkg.sv
// Shared definitions for the loadable code memory.
// Holds the default frame start marker, the loader FSM state encoding
// (whose order is also the frame field order) and an address-mask helper.
package code_mem_loadable_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Frame layout on the wire: SYNC, ADDR_H, ADDR_L, LEN, DATA x LEN, CHK.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_H = 3'd1,
    ST_ADDR_L = 3'd2,
    ST_LEN    = 3'd3,
    ST_DATA   = 3'd4,
    ST_CHK    = 3'd5
  } state_e;

  // Mask that keeps the low 'aw' bits of a 16-bit code address.
  function automatic logic [15:0] addr_mask(input int unsigned aw);
    return 16'((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/code_mem_frame_parser.sv
// Loader frame parser for the loadable code memory.
// Consumes a valid/ready byte stream, tracks the frame fields, and produces
// a one-byte-per-cycle write port into the code memory.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ld_valid, ld_data loader byte stream in
//   ld_ready          loader may present a byte (low only while in reset)
//   busy              a frame is in progress
//   done              one-cycle pulse after a frame with a good checksum
//   err               sticky: last frame had a checksum mismatch
//   we, waddr, wdata  code memory write port
module code_mem_frame_parser
  import code_mem_loadable_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 8,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_data,
  output logic                 ld_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 we,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic [7:0]           wdata
);

  localparam logic [15:0] ADDR_MASK = addr_mask(ADDRWIDTH);

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;
  logic [7:0]  sum_next;

  assign ld_ready = ~rst;
  assign accept   = ld_valid & ld_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    done_d   = 1'b0;
    err_d    = err_q;
    sum_next = sum_q + ld_data;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (ld_data == SYNC_BYTE) begin
            state_d = ST_ADDR_H;
            err_d   = 1'b0;
            sum_d   = '0;
          end
        end
        ST_ADDR_H: begin
          // Address bits at or above ADDRWIDTH are masked away here, so the
          // upper part of ptr_q stays zero and DATA increments wrap at DEPTH.
          ptr_d   = {ld_data, ptr_q[7:0]} & ADDR_MASK;
          sum_d   = sum_next;
          state_d = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          ptr_d   = {ptr_q[15:8], ld_data} & ADDR_MASK;
          sum_d   = sum_next;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          cnt_d   = (ld_data == 8'h00) ? 9'd256 : {1'b0, ld_data};
          sum_d   = sum_next;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          ptr_d = (ptr_q + 16'd1) & ADDR_MASK;
          cnt_d = cnt_q - 9'd1;
          sum_d = sum_next;
          if (cnt_q == 9'd1) state_d = ST_CHK;
        end
        ST_CHK: begin
          sum_d = sum_next;
          if (sum_next == 8'h00) done_d = 1'b1;
          else                   err_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign we    = accept && (state_q == ST_DATA);
  assign waddr = ptr_q[ADDRWIDTH-1:0];
  assign wdata = ld_data;

endmodule

// File: rtl/code_mem_loadable.sv
// Field-loadable program memory for the MCU51 core.
// CPU side reads through a negedge data register and a tri-state output;
// loader side writes code bytes from framed byte streams at run time.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (memory unaffected)
//   CS              chip select, active low; dout is high-Z when CS is high
//   addr, dout      CPU read address and data
//   ld_valid, ld_data, ld_ready   loader byte handshake
//   busy, done, err frame status (see code_mem_frame_parser)
module code_mem_loadable
  import code_mem_loadable_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 8,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CS,
  input  logic [ADDRWIDTH-1:0] addr,
  output logic [7:0]           dout,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_data,
  output logic                 ld_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned DEPTH = 2 ** ADDRWIDTH;

  logic [7:0]           mem [DEPTH] = '{default: 8'h00};
  logic                 we;
  logic [ADDRWIDTH-1:0] waddr;
  logic [7:0]           wdata;
  logic [7:0]           data_q, data_d;

  code_mem_frame_parser #(
    .ADDRWIDTH (ADDRWIDTH),
    .SYNC_BYTE (SYNC_BYTE)
  ) u_parser (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  // Memory contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    data_d = mem[addr];
  end

  // Read on the falling edge so a byte written at posedge is visible
  // half a cycle later, and reads never stall during loading.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign dout = CS ? 8'hzz : data_q;

endmodule

// File: tb/tb_code_mem_loadable.sv
module tb_code_mem_loadable;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CS = 1'b1;
  logic [7:0] addr = 8'h00;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  wire  [7:0] dout;
  wire        ld_ready, busy, done, err;

  always #5 clk = ~clk;

  code_mem_loadable #(
    .ADDRWIDTH (8),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .CS       (CS),
    .addr     (addr),
    .dout     (dout),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit check_en = 1'b0;

  // Frame-level model: memory image, bytes of the current frame, status.
  logic [7:0] mem_m [256];
  logic [7:0] fq [$];
  bit         m_done = 1'b0;
  bit         m_err = 1'b0;
  logic [7:0] fb [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // High-Z check; a two-state simulator resolves an undriven bus to 0.
  task automatic chk_hz(input string name);
    total++;
    if (!(dout === 8'hzz || dout === 8'h00)) begin
      bad++;
      $display("FAIL %s: got %h expected zz at %0t", name, dout, $time);
    end
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = 8'h00;
  end

  always @(posedge clk or posedge rst) begin : model
    int n, len;
    logic [7:0] s;
    if (rst) begin
      fq.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (ld_valid) begin
        if (fq.size() == 0) begin
          if (ld_data == 8'hA5) begin
            fq.push_back(ld_data);
            m_err = 1'b0;
          end
        end else begin
          fq.push_back(ld_data);
          n = fq.size() - 1;  // field index of this byte within the frame
          if (n >= 4) begin
            len = (fq[3] == 8'h00) ? 256 : int'(fq[3]);
            if (n <= 3 + len) begin
              mem_m[fq[2] + 8'(n - 4)] = ld_data;
            end else begin
              s = 8'h00;
              for (int k = 1; k <= n; k++) s = s + fq[k];
              if (s == 8'h00) m_done = 1'b1;
              else            m_err  = 1'b1;
              fq.delete();
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (check_en) begin
      chk("ld_ready", {15'd0, ld_ready}, {15'd0, !rst});
      chk("busy", {15'd0, busy}, {15'd0, fq.size() != 0});
      chk("done", {15'd0, done}, {15'd0, m_done});
      chk("err", {15'd0, err}, {15'd0, m_err});
      if (!CS) chk("dout", {8'd0, dout}, {8'd0, rst ? 8'h00 : mem_m[addr]});
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit toggle);
    foreach (fb[i]) begin
      ld_valid = 1'b1;
      ld_data  = fb[i];
      step(1);
      if (toggle) begin
        ld_valid = 1'b0;
        step(1);
      end
    end
    ld_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    addr = a;
    CS   = 1'b0;
    @(negedge clk);
    #2;
    chk(name, {8'd0, dout}, {8'd0, exp});
    step(1);
  endtask

  initial begin
    rst = 1'b1;
    step(3);
    chk("rst_ld_ready", {15'd0, ld_ready}, 16'd0);
    rst = 1'b0;
    check_en = 1'b1;
    step(1);

    // 1: reset state
    chk("init_ld_ready", {15'd0, ld_ready}, 16'd1);
    chk("init_busy", {15'd0, busy}, 16'd0);
    chk("init_err", {15'd0, err}, 16'd0);
    rd(8'h10, 8'h00, "init_read");
    CS = 1'b1;
    #1;
    chk_hz("init_hiz");
    CS = 1'b0;

    // 2: good frame
    fb = '{8'hA5, 8'h00, 8'hC2, 8'h03, 8'h74, 8'hFF, 8'h04, 8'hC4};
    send(1'b0);
    step(2);
    chk("t2_done_cnt", 16'(done_cnt), 16'd1);
    chk("t2_err", {15'd0, err}, 16'd0);
    rd(8'hC2, 8'h74, "t2_c2");
    rd(8'hC3, 8'hFF, "t2_c3");
    rd(8'hC4, 8'h04, "t2_c4");
    addr = 8'hC3;
    CS = 1'b1;
    #1;
    chk_hz("t2_hiz");
    CS = 1'b0;

    // 3: bad checksum, sticky err, cleared by next SYNC
    fb = '{8'hA5, 8'h00, 8'hC2, 8'h03, 8'h74, 8'hFF, 8'h04, 8'hC5};
    send(1'b0);
    step(2);
    chk("t3_err", {15'd0, err}, 16'd1);
    chk("t3_done_cnt", 16'(done_cnt), 16'd1);
    step(5);
    chk("t3_err_sticky", {15'd0, err}, 16'd1);
    fb = '{8'hA5};
    send(1'b0);
    chk("t3_err_clr", {15'd0, err}, 16'd0);
    chk("t3_busy", {15'd0, busy}, 16'd1);

    // 4: rest of the frame, address wraps FF -> 00
    fb = '{8'h00, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCC};
    send(1'b0);
    step(2);
    rd(8'hFF, 8'h11, "t4_ff");
    rd(8'h00, 8'h22, "t4_00");
    chk("t4_done_cnt", 16'(done_cnt), 16'd2);
    chk("t4_err", {15'd0, err}, 16'd0);

    // 5: garbage then a gappy frame carrying SYNC as data
    fb = '{8'h00, 8'h5A, 8'hA5, 8'h00, 8'h40, 8'h02, 8'hA5, 8'h5A, 8'hBF};
    send(1'b1);
    step(2);
    rd(8'h40, 8'hA5, "t5_40");
    rd(8'h41, 8'h5A, "t5_41");
    chk("t5_done_cnt", 16'(done_cnt), 16'd3);
    chk("t5_err", {15'd0, err}, 16'd0);

    // 6: reset in the middle of DATA
    fb = '{8'hA5, 8'h00, 8'h80, 8'h03, 8'h11};
    send(1'b0);
    chk("t6_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy_rst", {15'd0, busy}, 16'd0);
    step(2);
    rst = 1'b0;
    step(2);
    rd(8'h80, 8'h11, "t6_80");
    rd(8'h81, 8'h00, "t6_81");
    rd(8'h82, 8'h00, "t6_82");
    chk("t6_done_cnt", 16'(done_cnt), 16'd3);
    chk("t6_busy_after", {15'd0, busy}, 16'd0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
